// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel-to-serial framed bit transmitter.
// Captures a WIDTH-bit word on load && ready and shifts it out one bit per clock as
// start bit, data bits and (optionally) an even-parity bit.
// Optional feature macro: SERIAL_WORD_TX_PARITY_EN adds the parity bit after the data bits.
module serial_word_tx #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             x_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned    CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

`ifdef SERIAL_WORD_TX_PARITY_EN
    typedef enum logic [1:0] {StIdle, StStart, StData, StParity} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData} state_e;
`endif

    state_e           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [CntW-1:0]  cnt_q;
`ifdef SERIAL_WORD_TX_PARITY_EN
    logic             parity_q;
`endif

    logic             head_bit;
    logic [WIDTH-1:0] shift_next;

    // Bit at the outgoing end of the shift register and the register after consuming it.
    assign head_bit   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    assign shift_next = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

    // Frame sequencer; every output is registered so load never reaches an output directly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            cnt_q    <= '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
            x_out    <= IDLE_BIT;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // ready is always 1 here, so load alone completes the handshake.
                    if (load) begin
                        shift_q  <= data_in;
`ifdef SERIAL_WORD_TX_PARITY_EN
                        parity_q <= ^data_in;
`endif
                        state_q  <= StStart;
                        x_out    <= ~IDLE_BIT;
                        busy     <= 1'b1;
                        ready    <= 1'b0;
                    end
                end
                StStart: begin
                    x_out   <= head_bit;
                    shift_q <= shift_next;
                    cnt_q   <= '0;
                    state_q <= StData;
                end
                StData: begin
                    if (cnt_q == LastCnt) begin
`ifdef SERIAL_WORD_TX_PARITY_EN
                        x_out   <= parity_q;
                        state_q <= StParity;
`else
                        state_q <= StIdle;
                        x_out   <= IDLE_BIT;
                        busy    <= 1'b0;
                        ready   <= 1'b1;
                        done    <= 1'b1;
                        cnt_q   <= '0;
`endif
                    end else begin
                        x_out   <= head_bit;
                        shift_q <= shift_next;
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
`ifdef SERIAL_WORD_TX_PARITY_EN
                StParity: begin
                    state_q <= StIdle;
                    x_out   <= IDLE_BIT;
                    busy    <= 1'b0;
                    ready   <= 1'b1;
                    done    <= 1'b1;
                    cnt_q   <= '0;
                end
`endif
                default: begin
                    state_q <= StIdle;
                    x_out   <= IDLE_BIT;
                    busy    <= 1'b0;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule
